// File: rtl/cpu_route_pkg.sv
// Shared routing definitions for the ALU-result steering path: destination
// lane indices, the dest-index width helper and the {dest, data} entry type.
package cpu_route_pkg;

  localparam int unsigned DEST_GPR = 0;
  localparam int unsigned DEST_RAM = 1;
  localparam int unsigned DEST_PC  = 2;

  localparam int unsigned ROUTE_WIDTH    = 32;
  localparam int unsigned ROUTE_NUM_DEST = 3;

  // Width of a destination index able to address n lanes (at least 1 bit).
  function automatic int unsigned dest_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Entry for the default CPU configuration, shared with decoder and operand select.
  typedef struct packed {
    logic [dest_w(ROUTE_NUM_DEST)-1:0] dest;
    logic [ROUTE_WIDTH-1:0]            data;
  } route_entry_t;

endpackage

// File: rtl/result_router_if.sv
// Producer/consumer bundle of the result router: push side, per-lane
// delivery side, flush and status.
interface result_router_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_DEST = 3,
  parameter int unsigned DEPTH    = 4
);
  import cpu_route_pkg::*;

  localparam int unsigned DEST_W = dest_w(NUM_DEST);

  logic                      in_valid;
  logic                      in_ready;
  logic [DEST_W-1:0]         in_dest;
  logic [WIDTH-1:0]          in_data;
  logic [NUM_DEST-1:0]       out_valid;
  logic [NUM_DEST*WIDTH-1:0] out_data;
  logic [NUM_DEST-1:0]       out_ready;
  logic                      flush;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                      err_dest;

  // Environment side: producer, consumers and branch unit.
  modport master (
    output in_valid, in_dest, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count, err_dest
  );

  // Router side.
  modport slave (
    input  in_valid, in_dest, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count, err_dest
  );
endinterface

// File: rtl/result_fifo.sv
// DEPTH-entry FIFO with explicit occupancy counter and synchronous flush.
// Storage is not reset; only pointers and count are.
module result_fifo #(
  parameter int unsigned W     = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer/count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset beats flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/result_router.sv
// Buffers tagged ALU results and presents the FIFO head to exactly one
// destination lane; entries with an out-of-range dest are dropped with err_dest.
module result_router
  import cpu_route_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_DEST = 3,
  parameter int unsigned DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  result_router_if.slave   bus
);
  localparam int unsigned DEST_W  = dest_w(NUM_DEST);
  localparam int unsigned ENTRY_W = DEST_W + WIDTH;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [WIDTH-1:0]  data;
  } entry_t;

  entry_t wr_entry, head;
  logic   full, empty, push, pop, head_legal, lane_pop, drop;

  assign wr_entry     = '{dest: bus.in_dest, data: bus.in_data};
  assign bus.in_ready = !full && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;

  result_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (bus.count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_legal = (32'(head.dest) < NUM_DEST);

  // Lane demux of the registered head: one-hot valid, unselected lanes zero.
  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int unsigned i = 0; i < NUM_DEST; i++) begin
      if (!empty && head_legal && (head.dest == DEST_W'(i))) begin
        bus.out_valid[i]               = 1'b1;
        bus.out_data[i*WIDTH +: WIDTH] = head.data;
      end
    end
  end

  // Illegal heads pop themselves in the cycle they appear and flag err_dest.
  assign lane_pop     = |(bus.out_valid & bus.out_ready);
  assign drop         = !empty && !head_legal;
  assign pop          = lane_pop || drop;
  assign bus.err_dest = drop;

endmodule

// File: tb/tb_result_router.sv
// Bench for result_router: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations and a delivery log.
module tb_result_router;
  import cpu_route_pkg::*;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned NUM_DEST = 3;
  localparam int unsigned DEPTH    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_router_if #(.WIDTH(WIDTH), .NUM_DEST(NUM_DEST), .DEPTH(DEPTH)) bus ();

  result_router #(.WIDTH(WIDTH), .NUM_DEST(NUM_DEST), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned dest;
    logic [31:0] data;
  } ment_t;

  ment_t mq[$];     // reference FIFO contents
  ment_t dlog[$];   // deliveries observed at the DUT lanes
  ment_t dexp[$];   // deliveries required by the directed scenarios

  int n_cmp  = 0;
  int n_fail = 0;
  int err_pulses = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pop by head rules, push by occupancy, flush clears, reset wins.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      automatic int unsigned sz = mq.size();
      automatic bit acc = bus.in_valid && (sz < DEPTH) && !bus.flush;
      automatic ment_t e;
      for (int i = 0; i < NUM_DEST; i++)
        if (bus.out_valid[i] && bus.out_ready[i])
          dlog.push_back('{dest: i, data: bus.out_data[i*WIDTH +: WIDTH]});
      if (sz > 0) begin
        if (mq[0].dest >= NUM_DEST || bus.out_ready[mq[0].dest])
          void'(mq.pop_front());
      end
      if (acc) begin
        e.dest = bus.in_dest;
        e.data = bus.in_data;
        mq.push_back(e);
      end
      if (bus.flush) mq.delete();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic [NUM_DEST-1:0]       ev = '0;
      automatic logic [NUM_DEST*WIDTH-1:0] ed = '0;
      automatic logic                      ee = 1'b0;
      if (mq.size() > 0) begin
        if (mq[0].dest < NUM_DEST) begin
          ev[mq[0].dest] = 1'b1;
          ed[mq[0].dest*WIDTH +: WIDTH] = mq[0].data;
        end else begin
          ee = 1'b1;
        end
      end
      chk("m_out_valid", 128'(bus.out_valid), 128'(ev));
      chk("m_out_data",  128'(bus.out_data),  128'(ed));
      chk("m_err_dest",  128'(bus.err_dest),  128'(ee));
      chk("m_count",     128'(bus.count),     128'(mq.size()));
      chk("m_in_ready",  128'(bus.in_ready),  128'((mq.size() < DEPTH) && !bus.flush));
      if (bus.err_dest === 1'b1) err_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input int unsigned d, input logic [31:0] v);
    bus.in_valid = 1'b1;
    bus.in_dest  = 2'(d);
    bus.in_data  = v;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_dest   = '0;
    bus.in_data   = '0;
    bus.out_ready = '1;
    bus.flush     = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_count",     128'(bus.count),     128'(0));
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data",  128'(bus.out_data),  128'(0));
    chk("rst_err_dest",  128'(bus.err_dest),  128'(0));

    // Single push to the PC lane.
    push1(DEST_PC, 32'hDEADBEEF);
    #1;
    chk("single_valid",  128'(bus.out_valid),       128'(3'b100));
    chk("single_lane2",  128'(bus.out_data[95:64]), 128'(32'hDEADBEEF));
    chk("single_lane01", 128'(bus.out_data[63:0]),  128'(0));
    step(); #1;
    chk("single_count",  128'(bus.count), 128'(0));
    dexp.push_back('{dest: 2, data: 32'hDEADBEEF});

    // Fill to full with consumers stalled, try one more push, then drain.
    bus.out_ready = '0;
    for (int i = 1; i <= 4; i++) push1(DEST_GPR, 32'(i));
    bus.in_valid = 1'b1;
    bus.in_dest  = 2'd0;
    bus.in_data  = 32'h99;
    #1;
    chk("full_count",    128'(bus.count),    128'(4));
    chk("full_in_ready", 128'(bus.in_ready), 128'(0));
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("full_hold", 128'(bus.count), 128'(4));
    bus.out_ready = '1;
    step(); #1;
    chk("drain1_count", 128'(bus.count),    128'(3));
    chk("drain1_ready", 128'(bus.in_ready), 128'(1));
    repeat (3) step();
    #1;
    chk("drain_done", 128'(bus.count), 128'(0));
    for (int i = 1; i <= 4; i++) dexp.push_back('{dest: 0, data: 32'(i)});

    // Mixed destinations with the RAM lane stalled.
    bus.out_ready = 3'b101;
    push1(DEST_GPR, 32'h10);
    push1(DEST_RAM, 32'h11);
    push1(DEST_PC,  32'h12);
    push1(DEST_RAM, 32'h13);
    repeat (2) step();
    #1;
    chk("stall_count", 128'(bus.count),        128'(3));
    chk("stall_valid", 128'(bus.out_valid),    128'(3'b010));
    chk("stall_data",  128'(bus.out_data[63:32]), 128'(32'h11));
    bus.out_ready = '1;
    repeat (3) step();
    #1;
    chk("mixed_done", 128'(bus.count), 128'(0));
    dexp.push_back('{dest: 0, data: 32'h10});
    dexp.push_back('{dest: 1, data: 32'h11});
    dexp.push_back('{dest: 2, data: 32'h12});
    dexp.push_back('{dest: 1, data: 32'h13});

    // Flush with three entries buffered and a push offered.
    bus.out_ready = '0;
    push1(DEST_GPR, 32'h20);
    push1(DEST_GPR, 32'h21);
    push1(DEST_GPR, 32'h22);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77;
    bus.flush    = 1'b1;
    #1;
    chk("flush_in_ready", 128'(bus.in_ready), 128'(0));
    chk("flush_pre",      128'(bus.count),    128'(3));
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_count", 128'(bus.count),     128'(0));
    chk("flush_valid", 128'(bus.out_valid), 128'(0));
    bus.out_ready = '1;
    repeat (2) step();

    // Reset a full FIFO while consumers are ready.
    bus.out_ready = '0;
    for (int i = 0; i < 4; i++) push1(DEST_RAM, 32'h30 + 32'(i));
    bus.out_ready = '1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rrst_count",    128'(bus.count),     128'(0));
    chk("rrst_valid",    128'(bus.out_valid), 128'(0));
    chk("rrst_data",     128'(bus.out_data),  128'(0));
    chk("rrst_in_ready", 128'(bus.in_ready),  128'(1));
    repeat (3) step();

    // Illegal destination followed by a legal one.
    bus.in_valid = 1'b1;
    bus.in_dest  = 2'd3;
    bus.in_data  = 32'h55;
    step();
    bus.in_dest  = 2'd0;
    bus.in_data  = 32'h66;
    #1;
    chk("ill_err",   128'(bus.err_dest),  128'(1));
    chk("ill_valid", 128'(bus.out_valid), 128'(0));
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("ill_err_off", 128'(bus.err_dest),       128'(0));
    chk("ill_next",    128'(bus.out_valid),      128'(3'b001));
    chk("ill_data",    128'(bus.out_data[31:0]), 128'(32'h66));
    step(); #1;
    chk("ill_count",  128'(bus.count), 128'(0));
    chk("err_pulses", 128'(err_pulses), 128'(1));
    dexp.push_back('{dest: 0, data: 32'h66});

    // Delivery log against the directed expectations.
    chk("dlog_size", 128'(dlog.size()), 128'(dexp.size()));
    for (int i = 0; i < dexp.size(); i++) begin
      if (i < dlog.size()) begin
        chk($sformatf("dlog_lane%0d", i), 128'(dlog[i].dest), 128'(dexp[i].dest));
        chk($sformatf("dlog_data%0d", i), 128'(dlog[i].data), 128'(dexp[i].data));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/result_router.md
# result_router

Registered, parametrised successor to the CPU's ALU-result steering logic. It accepts ALU results tagged with a destination index, buffers them in a DEPTH-entry FIFO, and presents the head entry to exactly one of NUM_DEST destination lanes (GPR, RAM, PC, …) with valid/ready handshaking per lane. It sits between the ALU output and the writeback, store and branch consumers. It adds backpressure, buffering, branch flush and illegal-destination detection.

## Interface
Parameters:
- WIDTH, 32, data width of one result
- NUM_DEST, 3, number of destination lanes (≥2)
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  rising-edge clock; the block's single clock
- rst  input  1  synchronous, active-high reset; sampled on the clk rising edge
- in_valid  input  1  producer offers a result
- in_ready  output  1  = !full && !flush (combinational)
- in_dest  input  $clog2(NUM_DEST)  destination index of the offered result
- in_data  input  WIDTH  result value
- out_valid  output  NUM_DEST  one-hot (or zero) valid per lane
- out_data  output  NUM_DEST*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]; non-selected lanes drive 0
- out_ready  input  NUM_DEST  per-lane consumer ready
- flush  input  1  discard all buffered and concurrently offered results (taken branch)
- count  output  $clog2(DEPTH+1)  current occupancy
- err_dest  output  1  one-cycle pulse when an entry with in_dest ≥ NUM_DEST is dropped

## Operation
- Push: in_valid && in_ready writes {in_dest, in_data} at wr_ptr. wr_ptr increments modulo DEPTH.
- Head: when count>0 and head dest<NUM_DEST, out_valid[head_dest]=1 and that lane carries head data. All other lanes have valid=0 and data=0. When count==0, all out_valid=0 and all out_data=0.
- Pop: out_valid[d] && out_ready[d]. rd_ptr increments modulo DEPTH. out_ready on non-selected lanes is ignored.
- Illegal dest: a head entry with dest ≥ NUM_DEST raises no out_valid. It is popped automatically in the cycle it reaches the head, and err_dest=1 for that cycle. This only applies when NUM_DEST is not a power of two.
- Occupancy: push only → count+1; pop only → count−1; push and pop together → unchanged. Full means count==DEPTH; empty means count==0.
- Flush: on a flush cycle, next state is rd_ptr=wr_ptr=0 and count=0. A pop in the same cycle still completes at the consumer, since its handshake was valid. A concurrent push is blocked because in_ready=0.
- Reset: rst has priority over flush and over all handshakes. Reset mid-operation discards all entries with no pops completing after the reset edge.
- FIFO storage contents are not reset. Only pointers, count and err_dest are reset.

## Timing
- Latency: a result pushed at edge t is visible on out_valid after edge t (the next cycle). There is no combinational fall-through from in_* to out_*.
- Throughput: 1 result/cycle sustained when the consumer holds ready.
- in_ready is deasserted when full. A push is therefore never accepted at count==DEPTH, even if a pop occurs in the same cycle. Producers see one bubble after a full condition.
- Lane outputs (out_valid, out_data) are decoded combinationally from registered head state. The only combinational input→output paths are flush→in_ready and the out_ready→pop decision feeding state.
- Reset values: in_ready=1, out_valid=0, out_data=0, count=0, err_dest=0.
- Pointers wrap from DEPTH−1 to 0. count uses an explicit counter rather than a pointer difference.

## Structure
- Shared package cpu_route_pkg holds:
  - DEST_GPR=0, DEST_RAM=1, DEST_PC=2
  - the dest-index width function
  - the typedef for a {dest, data} entry, shared with the decoder and the operand-select successor
- Sub-module result_fifo(WIDTH+DEST_W, DEPTH) provides storage, pointers, count and flush.
- result_router contains the head decode, lane demux, illegal-dest auto-pop and err_dest.

## Test plan
- Reset then single push (dest=2, data=0xDEADBEEF) with all ready=1 → out_valid=3'b100 the next cycle, lane 2 data 0xDEADBEEF, lanes 0/1 data 0; count returns to 0.
- Fill with 4 pushes (data 1..4, dest=0) and out_ready=0 → count=4, in_ready=0; release ready → pops 1,2,3,4 in order over 4 cycles; in_ready=1 after the first pop.
- Mixed dests 0,1,2,1 with out_ready[1] held low → stall at entry 2 (dest=1); entries behind it are not delivered; raising ready[1] resumes strict in-order delivery.
- Flush with count=3 and in_valid=1 in the same cycle → count=0 on the next cycle; the offered result is not stored; all out_valid=0.
- Full FIFO, assert rst for one cycle while out_ready=1 → count=0, outputs at reset values; no further pops are observed.
- With NUM_DEST=3, push dest=3 (data 0x55) followed by dest=0 (data 0x66) → err_dest pulses once, no lane sees 0x55, lane 0 receives 0x66.
